turn_input_conditioner: RTL and testbench



---
 rtl/turn_pkg.sv | 16 +
 rtl/sync_debounce.sv | 46 ++++
 rtl/turn_input_conditioner.sv | 127 ++++++++++++
 tb/tb_turn_input_conditioner.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/turn_pkg.sv
// Shared definitions for the turn-signal input conditioner: playback FSM
// encoding and ROM entry bit positions.
package turn_pkg;

  typedef enum logic [1:0] {
    MANUAL    = 2'd0,
    FETCH     = 2'd1,
    WAIT_DATA = 2'd2,
    HOLD      = 2'd3
  } state_e;

  localparam int unsigned MEM_HAZARD = 0;
  localparam int unsigned MEM_TURN   = 1;
  localparam int unsigned MEM_SIDE   = 2;

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchroniser followed by a tick-counted debouncer for one raw input.
module sync_debounce #(
  parameter logic        RESET_VAL      = 1'b0,
  parameter int unsigned DEBOUNCE_TICKS = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic tick,
  input  logic raw,
  output logic stable
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_TICKS);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_TICKS - 1);

  logic            meta_q;
  logic            sync_q;
  logic            stable_q;
  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      meta_q   <= RESET_VAL;
      sync_q   <= RESET_VAL;
      stable_q <= RESET_VAL;
      cnt_q    <= '0;
    end else begin
      meta_q <= raw;
      sync_q <= meta_q;
      if (sync_q == stable_q) begin
        cnt_q <= '0;
      end else if (tick) begin
        // Flip only on the tick that completes a full run of differing ticks.
        if (cnt_q == CntMax) begin
          stable_q <= ~stable_q;
          cnt_q    <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign stable = stable_q;

endmodule

// File: rtl/turn_input_conditioner.sv
// Selects debounced manual switches or ROM playback as the hazard/turn/side
// levels for the tail-light state machine, and flags any level change.
module turn_input_conditioner #(
  parameter int unsigned DEBOUNCE_TICKS = 8,
  parameter int unsigned STEP_TICKS     = 16,
  parameter int unsigned ADDR_W         = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              tick,
  input  logic              sw_hazard,
  input  logic              sw_turn,
  input  logic              key_side,
  input  logic              sw_playback,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  output logic              hazard,
  output logic              turn,
  output logic              side,
  output logic              changed
);

  import turn_pkg::*;

  localparam int unsigned HoldW = $clog2(STEP_TICKS + 1);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(STEP_TICKS - 1);

  logic [2:0] db;
  logic       pb_meta_q, pb_sync_q;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [HoldW-1:0]  hold_q, hold_d;
  logic [2:0]        lvl_q, lvl_d;
  logic              changed_q, changed_d;

  logic unused_mem_bits;
  assign unused_mem_bits = ^mem_data[7:3];

  sync_debounce #(.RESET_VAL(1'b0), .DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_db_hazard (
    .clk(clk), .reset_n(reset_n), .tick(tick), .raw(sw_hazard), .stable(db[MEM_HAZARD])
  );
  sync_debounce #(.RESET_VAL(1'b0), .DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_db_turn (
    .clk(clk), .reset_n(reset_n), .tick(tick), .raw(sw_turn), .stable(db[MEM_TURN])
  );
  sync_debounce #(.RESET_VAL(1'b1), .DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_db_side (
    .clk(clk), .reset_n(reset_n), .tick(tick), .raw(key_side), .stable(db[MEM_SIDE])
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    hold_d  = hold_q;
    case (state_q)
      MANUAL: begin
        if (pb_sync_q) begin
          state_d = FETCH;
          addr_d  = '0;
        end
      end
      FETCH:     state_d = WAIT_DATA;
      WAIT_DATA: begin
        state_d = HOLD;
        hold_d  = '0;
      end
      HOLD: begin
        if (tick) begin
          if (hold_q == HoldMax) begin
            hold_d  = '0;
            addr_d  = addr_q + 1'b1;
            state_d = FETCH;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
      end
      default: state_d = MANUAL;
    endcase
    // Leaving playback overrides any step completing on the same edge.
    if (state_q != MANUAL && !pb_sync_q) begin
      state_d = MANUAL;
      addr_d  = '0;
      hold_d  = '0;
    end
  end

  // The output register doubles as the playback register: it is loaded from
  // the ROM in WAIT_DATA and otherwise held until playback ends.
  always_comb begin
    lvl_d = lvl_q;
    if (state_d == MANUAL) begin
      lvl_d = db;
    end else if (state_q == WAIT_DATA) begin
      lvl_d[MEM_HAZARD] = mem_data[MEM_HAZARD];
      lvl_d[MEM_TURN]   = mem_data[MEM_TURN];
      lvl_d[MEM_SIDE]   = mem_data[MEM_SIDE];
    end
    changed_d = (lvl_d != lvl_q);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pb_meta_q <= 1'b0;
      pb_sync_q <= 1'b0;
      state_q   <= MANUAL;
      addr_q    <= '0;
      hold_q    <= '0;
      lvl_q     <= 3'b100;
      changed_q <= 1'b0;
    end else begin
      pb_meta_q <= sw_playback;
      pb_sync_q <= pb_meta_q;
      state_q   <= state_d;
      addr_q    <= addr_d;
      hold_q    <= hold_d;
      lvl_q     <= lvl_d;
      changed_q <= changed_d;
    end
  end

  assign mem_addr = addr_q;
  assign hazard   = lvl_q[MEM_HAZARD];
  assign turn     = lvl_q[MEM_TURN];
  assign side     = lvl_q[MEM_SIDE];
  assign changed  = changed_q;

endmodule

// File: tb/tb_turn_input_conditioner.sv
// Randomised bench for turn_input_conditioner, compared every cycle against a
// behavioural model of the debounce and playback rules.
module tb_turn_input_conditioner;

  localparam int unsigned DB   = 8;
  localparam int unsigned STEP = 4;
  localparam int unsigned AW   = 2;
  localparam int unsigned NENT = 1 << AW;

  logic          clk;
  logic          reset_n;
  logic          tick;
  logic          sw_hazard, sw_turn, key_side, sw_playback;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_data;
  logic          hazard, turn, side, changed;

  logic [7:0] rom [NENT];

  int n_checks = 0;
  int n_errors = 0;

  // Model state: channel 0 hazard, 1 turn, 2 side key, 3 playback.
  bit [3:0] m_s1, m_s2;
  bit [2:0] m_deb;
  int       m_dcnt [3];
  bit       m_in_pb;
  int       m_fetch;   // 2 = fetching, 1 = waiting for data, 0 = holding
  int       m_tcnt;
  int       m_idx;
  bit [2:0] m_out;
  bit       m_chg;

  turn_input_conditioner #(
    .DEBOUNCE_TICKS(DB),
    .STEP_TICKS    (STEP),
    .ADDR_W        (AW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .tick       (tick),
    .sw_hazard  (sw_hazard),
    .sw_turn    (sw_turn),
    .key_side   (key_side),
    .sw_playback(sw_playback),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .hazard     (hazard),
    .turn       (turn),
    .side       (side),
    .changed    (changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered ROM: data valid one clk after the address.
  always_ff @(posedge clk) mem_data <= rom[mem_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    bit [3:0] raw;
    bit [2:0] deb_old, out_old;
    bit       pb;
    raw = {sw_playback, key_side, sw_turn, sw_hazard};
    if (!reset_n) begin
      m_s1    = 4'b0100;
      m_s2    = 4'b0100;
      m_deb   = 3'b100;
      for (int i = 0; i < 3; i++) m_dcnt[i] = 0;
      m_in_pb = 0;
      m_fetch = 0;
      m_tcnt  = 0;
      m_idx   = 0;
      m_out   = 3'b100;
      m_chg   = 0;
      return;
    end
    deb_old = m_deb;
    out_old = m_out;
    pb      = m_s2[3];
    // A run of DB differing ticks flips the debounced value.
    for (int i = 0; i < 3; i++) begin
      if (m_s2[i] == m_deb[i]) m_dcnt[i] = 0;
      else if (tick) begin
        m_dcnt[i]++;
        if (m_dcnt[i] == DB) begin
          m_deb[i]  = ~m_deb[i];
          m_dcnt[i] = 0;
        end
      end
    end
    m_s2 = m_s1;
    m_s1 = raw;
    if (!m_in_pb) begin
      if (pb) begin
        m_in_pb = 1;
        m_fetch = 2;
        m_idx   = 0;
      end else begin
        m_out = deb_old;
      end
    end else if (!pb) begin
      m_in_pb = 0;
      m_idx   = 0;
      m_out   = deb_old;
    end else if (m_fetch == 2) begin
      m_fetch = 1;
    end else if (m_fetch == 1) begin
      m_fetch = 0;
      m_tcnt  = 0;
      m_out   = rom[m_idx][2:0];
    end else if (tick) begin
      m_tcnt++;
      if (m_tcnt == STEP) begin
        m_idx   = (m_idx + 1) % NENT;
        m_fetch = 2;
      end
    end
    m_chg = (m_out != out_old);
  endtask

  bit [3:0] lvl;
  int       dur [4];
  bit       did_wd_rst;
  bit       rom_rand;

  initial begin
    rom[0] = 8'h01;
    rom[1] = 8'h02;
    rom[2] = 8'h06;
    rom[3] = 8'h00;
    reset_n     = 1'b0;
    tick        = 1'b0;
    lvl         = 4'b0000;   // key_side held low through reset
    dur[0]      = 30;
    dur[1]      = 30;
    dur[2]      = 100;
    dur[3]      = 300;
    sw_hazard   = 1'b0;
    sw_turn     = 1'b0;
    key_side    = 1'b0;
    sw_playback = 1'b0;
    did_wd_rst  = 0;
    rom_rand    = 0;

    for (int cyc = 0; cyc < 6000; cyc++) begin
      @(negedge clk);
      if (cyc < 3) reset_n = 1'b0;
      else if (!did_wd_rst && cyc > 500 && m_in_pb && m_fetch == 1) begin
        reset_n    = 1'b0;
        did_wd_rst = 1;
      end else reset_n = ($urandom_range(0, 1999) != 0);
      tick = ($urandom_range(0, 2) == 0);
      for (int i = 0; i < 4; i++) begin
        if (dur[i] == 0) begin
          lvl[i] = 1'($urandom_range(0, 1));
          dur[i] = (i == 3) ? $urandom_range(20, 400) : $urandom_range(1, 60);
        end
        dur[i]--;
      end
      {sw_playback, key_side, sw_turn, sw_hazard} = lvl;
      // Swap in a ROM with junk upper bits once, only while not in playback.
      if (cyc >= 3000 && !rom_rand && !m_in_pb) begin
        for (int i = 0; i < NENT; i++) rom[i] = 8'($urandom);
        rom_rand = 1;
      end
      @(posedge clk);
      model_step();
      #1;
      check("hazard",   32'(hazard),   32'(m_out[0]));
      check("turn",     32'(turn),     32'(m_out[1]));
      check("side",     32'(side),     32'(m_out[2]));
      check("changed",  32'(changed),  32'(m_chg));
      check("mem_addr", 32'(mem_addr), 32'(m_idx));
    end
    check("wait_data_reset_seen", 32'(did_wd_rst), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
